addr_packet_switch: RTL and testbench

// Parametrised address-routed switch between the SPI minion adapter (host) and N on-chip endpoints.

---
 rtl/addr_packet_switch.sv | 218 +++++++++++++++++++++
 tb/tb_addr_packet_switch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_packet_switch.sv
// addr_packet_switch: routes host packets to N endpoints by address and merges
// endpoint traffic back to the host through per-endpoint FIFOs and an arbiter.

// aps_lane: one endpoint slice holding the downstream output register and
// the upstream FIFO. With LOOPBACK set, the output register drains straight
// into the FIFO and the external endpoint handshake is disabled.
module aps_lane #(
  parameter int BIT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 2,
  parameter bit LOOPBACK   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dn_push,
  input  logic [BIT_WIDTH-1:0] dn_data,
  output logic                 dn_rdy,
  output logic                 ep_send_val,
  input  logic                 ep_send_rdy,
  output logic [BIT_WIDTH-1:0] ep_send_msg,
  input  logic                 ep_recv_val,
  output logic                 ep_recv_rdy,
  input  logic [BIT_WIDTH-1:0] ep_recv_msg,
  input  logic                 up_pop,
  output logic                 up_empty,
  output logic [BIT_WIDTH-1:0] up_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                                  out_val_q, out_val_d;
  logic [BIT_WIDTH-1:0]                  out_data_q, out_data_d;
  logic [FIFO_DEPTH-1:0][BIT_WIDTH-1:0]  mem_q, mem_d;
  logic [PW-1:0]                         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic                                  full, drain, push;
  logic [BIT_WIDTH-1:0]                  push_data;

  // No bypass: a full FIFO refuses new data even when it pops this cycle.
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign up_empty  = (cnt_q == '0);
  assign up_data   = mem_q[rd_ptr_q];

  // The output register empties either to the endpoint or, in loopback, to the FIFO.
  assign drain       = out_val_q & (LOOPBACK ? !full : ep_send_rdy);
  assign dn_rdy      = !out_val_q | (LOOPBACK ? !full : ep_send_rdy);
  assign ep_send_val = LOOPBACK ? 1'b0 : out_val_q;
  assign ep_send_msg = out_data_q;
  assign ep_recv_rdy = LOOPBACK ? 1'b0 : !full;
  assign push        = LOOPBACK ? drain : (ep_recv_val & !full);
  assign push_data   = LOOPBACK ? out_data_q : ep_recv_msg;

  // Next state for the output register and the FIFO.
  always_comb begin
    out_val_d  = out_val_q;
    out_data_d = out_data_q;
    if (drain) out_val_d = 1'b0;
    if (dn_push) begin
      out_val_d  = 1'b1;
      out_data_d = dn_data;
    end
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (up_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, up_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; FIFO storage is data only and needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      out_val_q  <= out_val_d;
      out_data_q <= out_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
    mem_q <= mem_d;
  end
endmodule

module addr_packet_switch #(
  parameter int BIT_WIDTH   = 32,
  parameter int N_ENDPOINTS = 16,
  parameter int FIFO_DEPTH  = 2,
  parameter int ARB_MODE    = 1,
  parameter int LOOPBACK_EN = 1,
  localparam int ADDR_BITS  = $clog2(N_ENDPOINTS)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    host_recv_val,
  output logic                                    host_recv_rdy,
  input  logic [BIT_WIDTH+ADDR_BITS-1:0]          host_recv_msg,
  output logic                                    host_send_val,
  input  logic                                    host_send_rdy,
  output logic [BIT_WIDTH+ADDR_BITS-1:0]          host_send_msg,
  output logic [N_ENDPOINTS-1:0]                  ep_send_val,
  input  logic [N_ENDPOINTS-1:0]                  ep_send_rdy,
  output logic [N_ENDPOINTS-1:0][BIT_WIDTH-1:0]   ep_send_msg,
  input  logic [N_ENDPOINTS-1:0]                  ep_recv_val,
  output logic [N_ENDPOINTS-1:0]                  ep_recv_rdy,
  input  logic [N_ENDPOINTS-1:0][BIT_WIDTH-1:0]   ep_recv_msg,
  output logic [15:0]                             pkt_in_count,
  output logic [15:0]                             pkt_out_count
);
  typedef logic [ADDR_BITS-1:0] addr_t;

  addr_t                                 host_addr, gnt_idx, arb_start, cand;
  logic [BIT_WIDTH-1:0]                  host_payload;
  logic [N_ENDPOINTS-1:0]                dn_push, dn_rdy, up_pop, up_empty;
  logic [N_ENDPOINTS-1:0][BIT_WIDTH-1:0] up_data;
  logic                                  host_recv_fire, host_send_fire, arb_en, gnt_any;
  logic                                  hs_val_q, hs_val_d;
  logic [BIT_WIDTH+ADDR_BITS-1:0]        hs_msg_q, hs_msg_d;
  addr_t                                 ptr_q, ptr_d;
  logic [15:0]                           in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;

  assign host_addr      = host_recv_msg[BIT_WIDTH+ADDR_BITS-1:BIT_WIDTH];
  assign host_payload   = host_recv_msg[BIT_WIDTH-1:0];
  // Only the addressed lane can stall the host.
  assign host_recv_rdy  = dn_rdy[host_addr];
  assign host_recv_fire = host_recv_val & host_recv_rdy;
  assign host_send_val  = hs_val_q;
  assign host_send_msg  = hs_msg_q;
  assign host_send_fire = hs_val_q & host_send_rdy;
  // The host register can take a new winner when empty or draining this cycle.
  assign arb_en         = !hs_val_q | host_send_rdy;
  assign pkt_in_count   = in_cnt_q;
  assign pkt_out_count  = out_cnt_q;

  for (genvar i = 0; i < N_ENDPOINTS; i++) begin : g_lane
    assign dn_push[i] = host_recv_fire & (host_addr == addr_t'(i));
    assign up_pop[i]  = arb_en & gnt_any & (gnt_idx == addr_t'(i));
    aps_lane #(
      .BIT_WIDTH (BIT_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH),
      .LOOPBACK  (bit'((LOOPBACK_EN != 0) && (i == 0)))
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .dn_push    (dn_push[i]),
      .dn_data    (host_payload),
      .dn_rdy     (dn_rdy[i]),
      .ep_send_val(ep_send_val[i]),
      .ep_send_rdy(ep_send_rdy[i]),
      .ep_send_msg(ep_send_msg[i]),
      .ep_recv_val(ep_recv_val[i]),
      .ep_recv_rdy(ep_recv_rdy[i]),
      .ep_recv_msg(ep_recv_msg[i]),
      .up_pop     (up_pop[i]),
      .up_empty   (up_empty[i]),
      .up_data    (up_data[i])
    );
  end

  // Pick the first non-empty FIFO, scanning from ptr+1 (round-robin) or from 0 (fixed).
  always_comb begin
    arb_start = (ARB_MODE != 0) ? addr_t'(ptr_q + 1'b1) : '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_ENDPOINTS; k++) begin
      cand = arb_start + addr_t'(k);
      if (!gnt_any && !up_empty[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Host output register, round-robin pointer and packet counters.
  always_comb begin
    hs_val_d = hs_val_q;
    hs_msg_d = hs_msg_q;
    ptr_d    = ptr_q;
    if (arb_en) begin
      hs_val_d = gnt_any;
      if (gnt_any) begin
        hs_msg_d = {gnt_idx, up_data[gnt_idx]};
        if (ARB_MODE != 0) ptr_d = gnt_idx;
      end
    end
    in_cnt_d  = in_cnt_q + 16'(host_recv_fire);
    out_cnt_d = out_cnt_q + 16'(host_send_fire);
  end

  // Reset leaves the pointer on the last endpoint so endpoint 0 is first served.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_val_q  <= 1'b0;
      hs_msg_q  <= '0;
      ptr_q     <= addr_t'(N_ENDPOINTS - 1);
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      hs_val_q  <= hs_val_d;
      hs_msg_q  <= hs_msg_d;
      ptr_q     <= ptr_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end
endmodule

// File: tb/tb_addr_packet_switch.sv
// Scoreboard bench for addr_packet_switch: a round-robin/loopback instance and a
// fixed-priority instance without loopback.
module tb_addr_packet_switch;
  localparam int N = 16, BW = 32, AW = 4, MW = BW + AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic hrv, hrr, hsv, hsr;
  logic [MW-1:0] hrm, hsm;
  logic [N-1:0] esv, esr, erv, err;
  logic [N-1:0][BW-1:0] esm, erm;
  logic [15:0] pic, poc;

  logic f_hrr, f_hsv, f_hsr;
  logic [MW-1:0] f_hsm;
  logic [N-1:0] f_esv, f_erv, f_err;
  logic [N-1:0][BW-1:0] f_esm, f_erm;
  logic [15:0] f_pic, f_poc;

  addr_packet_switch #(.BIT_WIDTH(BW), .N_ENDPOINTS(N), .FIFO_DEPTH(2),
                       .ARB_MODE(1), .LOOPBACK_EN(1)) dut (
    .clk(clk), .reset(reset),
    .host_recv_val(hrv), .host_recv_rdy(hrr), .host_recv_msg(hrm),
    .host_send_val(hsv), .host_send_rdy(hsr), .host_send_msg(hsm),
    .ep_send_val(esv), .ep_send_rdy(esr), .ep_send_msg(esm),
    .ep_recv_val(erv), .ep_recv_rdy(err), .ep_recv_msg(erm),
    .pkt_in_count(pic), .pkt_out_count(poc));

  addr_packet_switch #(.BIT_WIDTH(BW), .N_ENDPOINTS(N), .FIFO_DEPTH(2),
                       .ARB_MODE(0), .LOOPBACK_EN(0)) dut_fp (
    .clk(clk), .reset(reset),
    .host_recv_val(1'b0), .host_recv_rdy(f_hrr), .host_recv_msg({MW{1'b0}}),
    .host_send_val(f_hsv), .host_send_rdy(f_hsr), .host_send_msg(f_hsm),
    .ep_send_val(f_esv), .ep_send_rdy({N{1'b0}}), .ep_send_msg(f_esm),
    .ep_recv_val(f_erv), .ep_recv_rdy(f_err), .ep_recv_msg(f_erm),
    .pkt_in_count(f_pic), .pkt_out_count(f_poc));

  typedef struct { int ep; logic [BW-1:0] d; } ep_exp_t;
  logic [MW-1:0] exp_host[$];
  logic [MW-1:0] exp_fp[$];
  ep_exp_t       exp_ep[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name, input logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // Pops the expected queues whenever a transfer is about to happen at the next edge.
  task automatic monitor();
    bit found;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (hsv && hsr) begin
          if (exp_host.size() == 0) bad("host_send_unexpected", hsm);
          else chk("host_send_msg", hsm, exp_host.pop_front());
        end
        if (f_hsv && f_hsr) begin
          if (exp_fp.size() == 0) bad("fp_host_send_unexpected", f_hsm);
          else chk("fp_host_send_msg", f_hsm, exp_fp.pop_front());
        end
        for (int i = 0; i < N; i++) begin
          if (esv[i] && esr[i]) begin
            found = 1'b0;
            for (int k = 0; k < exp_ep.size(); k++) begin
              if (!found && exp_ep[k].ep == i) begin
                found = 1'b1;
                chk($sformatf("ep%0d_send_msg", i), esm[i], exp_ep[k].d);
                exp_ep.delete(k);
              end
            end
            if (!found) bad($sformatf("ep%0d_send_unexpected", i), esm[i]);
          end
        end
      end
    end
  endtask

  task automatic send_host(input logic [AW-1:0] a, input logic [BW-1:0] d);
    int w = 0;
    hrv = 1'b1;
    hrm = {a, d};
    @(negedge clk);
    while (!hrr && w < 100) begin w++; @(negedge clk); end
    if (!hrr) bad("host_recv_timeout", hrm);
    @(posedge clk); #1;
    hrv = 1'b0;
  endtask

  task automatic ep_push(input bit fp, input int ep, input logic [BW-1:0] d);
    int w = 0;
    if (fp) begin f_erv[ep] = 1'b1; f_erm[ep] = d; end
    else begin erv[ep] = 1'b1; erm[ep] = d; end
    @(negedge clk);
    while (!(fp ? f_err[ep] : err[ep]) && w < 100) begin w++; @(negedge clk); end
    if (w >= 100) bad($sformatf("ep%0d_push_timeout", ep), d);
    @(posedge clk); #1;
    if (fp) f_erv[ep] = 1'b0; else erv[ep] = 1'b0;
  endtask

  task automatic fp_stream(input int ep, input int n);
    for (int k = 0; k < n; k++) ep_push(1'b1, ep, 32'(ep * 256 + k));
  endtask

  initial begin
    int w;
    hrv = 1'b0; hrm = '0; hsr = 1'b1; esr = '1; erv = '0; erm = '0;
    f_hsr = 1'b1; f_erv = '0; f_erm = '0;
    fork monitor(); join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_host_send_val", hsv, 0);
    chk("rst_ep_send_val", esv, 0);
    chk("rst_pkt_in", pic, 0);
    chk("rst_pkt_out", poc, 0);
    chk("rst_ep_recv_rdy", err, 16'hFFFE);
    chk("rst_fp_ep_recv_rdy", f_err, 16'hFFFF);
    chk("rst_host_recv_rdy", hrr, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // T1 loopback: visible on the third sample after acceptance
    exp_host.push_back({4'h0, 32'hDEADBEEF});
    send_host(4'h0, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_val_early", hsv, 0);
    @(negedge clk);
    chk("t1_val_early2", hsv, 0);
    chk("t1_ep0_send_val", esv[0], 0);
    @(negedge clk);
    chk("t1_val_cycle3", hsv, 1);
    chk("t1_msg_cycle3", hsm, {4'h0, 32'hDEADBEEF});
    @(negedge clk);
    chk("t1_pkt_in", pic, 1);
    chk("t1_pkt_out", poc, 1);

    // T2 routing and per-endpoint stall
    @(posedge clk); #1;
    esr[5] = 1'b0;
    exp_ep.push_back('{5, 32'h1});
    exp_ep.push_back('{5, 32'h2});
    exp_ep.push_back('{9, 32'h3});
    send_host(4'h5, 32'h1);
    hrv = 1'b1; hrm = {4'h5, 32'h2};
    @(negedge clk);
    chk("t2_stall_rdy", hrr, 0);
    chk("t2_ep5_val", esv[5], 1);
    chk("t2_ep5_msg", esm[5], 32'h1);
    repeat (2) @(negedge clk);
    chk("t2_stall_rdy_hold", hrr, 0);
    chk("t2_ep9_idle", esv[9], 0);
    chk("t2_ep5_msg_hold", esm[5], 32'h1);
    @(posedge clk); #1;
    esr[5] = 1'b1;
    @(negedge clk);
    chk("t2_pipelined_rdy", hrr, 1);
    @(posedge clk); #1;
    hrm = {4'h9, 32'h3};
    @(negedge clk);
    chk("t2_addr9_rdy", hrr, 1);
    @(posedge clk); #1;
    hrv = 1'b0;
    repeat (3) @(posedge clk);

    // T3 round-robin, twice from the same fill pattern
    for (int r = 0; r < 2; r++) begin
      #1;
      exp_host.push_back({4'h2, 32'(32'hA0 + r)});
      exp_host.push_back({4'h3, 32'(32'hB0 + r)});
      exp_host.push_back({4'h7, 32'(32'hC0 + r)});
      erv[2] = 1'b1; erm[2] = 32'(32'hA0 + r);
      erv[3] = 1'b1; erm[3] = 32'(32'hB0 + r);
      erv[7] = 1'b1; erm[7] = 32'(32'hC0 + r);
      @(posedge clk); #1;
      erv = '0;
      repeat (6) @(posedge clk);
    end
    @(negedge clk);
    chk("t3_pkt_in", pic, 4);
    chk("t3_pkt_out", poc, 7);

    // T5 backpressure on endpoint 4
    @(posedge clk); #1;
    hsr = 1'b0;
    exp_host.push_back({4'h4, 32'h5000_0000});
    exp_host.push_back({4'h4, 32'h5000_0001});
    exp_host.push_back({4'h4, 32'h5000_0002});
    ep_push(1'b0, 4, 32'h5000_0000);
    ep_push(1'b0, 4, 32'h5000_0001);
    ep_push(1'b0, 4, 32'h5000_0002);
    @(negedge clk);
    chk("t5_fifo_full_rdy", err[4], 0);
    chk("t5_host_val", hsv, 1);
    chk("t5_host_msg", hsm, {4'h4, 32'h5000_0000});
    repeat (3) @(negedge clk);
    chk("t5_host_msg_hold", hsm, {4'h4, 32'h5000_0000});
    chk("t5_fifo_full_hold", err[4], 0);
    @(posedge clk); #1;
    hsr = 1'b1;
    repeat (6) @(posedge clk);

    // T4 fixed priority on the second instance
    for (int e = 2; e <= 7; e++)
      if (e == 2 || e == 3 || e == 7)
        for (int k = 0; k < 4; k++) exp_fp.push_back({4'(e), 32'(e * 256 + k)});
    #1;
    fork
      fp_stream(2, 4);
      fp_stream(3, 4);
      fp_stream(7, 4);
    join
    repeat (6) @(posedge clk);

    // T6 reset with traffic in flight
    #1;
    hsr = 1'b0;
    esr[9] = 1'b0;
    ep_push(1'b0, 6, 32'h6000_0000);
    ep_push(1'b0, 6, 32'h6000_0001);
    ep_push(1'b0, 6, 32'h6000_0002);
    send_host(4'h9, 32'h99);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_host_val", hsv, 0);
    chk("t6_ep_val", esv, 0);
    chk("t6_pkt_in", pic, 0);
    chk("t6_pkt_out", poc, 0);
    chk("t6_ep6_rdy", err[6], 1);
    @(posedge clk); #1;
    reset = 1'b0;
    hsr = 1'b1;
    esr = '1;
    exp_ep.push_back('{9, 32'h55});
    exp_host.push_back({4'h0, 32'h77});
    send_host(4'h9, 32'h55);
    send_host(4'h0, 32'h77);

    // Drain and final accounting
    w = 0;
    while ((exp_host.size() + exp_ep.size() + exp_fp.size()) != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    @(negedge clk);
    chk("left_host", exp_host.size(), 0);
    chk("left_ep", exp_ep.size(), 0);
    chk("left_fp", exp_fp.size(), 0);
    chk("end_pkt_in", pic, 2);
    chk("end_pkt_out", poc, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
